// File: rtl/chany_bist_pkg.sv
// Shared types and constants for the Y-channel track BIST: FSM states,
// pattern-group offsets and derived-size helpers.
package chany_bist_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int PAT_ZERO  = 0;
  localparam int PAT_ONE   = 1;
  localparam int PAT_CBA   = 2;
  localparam int PAT_CBB   = 3;
  localparam int PAT_WALK1 = 4;

  // Walking-one and walking-zero groups each contribute one pattern per track.
  function automatic int num_pat(input int chan_width);
    return 2 * chan_width + PAT_WALK1;
  endfunction

  function automatic int err_w(input int chan_width);
    return $clog2(num_pat(chan_width) + 1);
  endfunction

endpackage

// File: rtl/chany_track_bist_if.sv
// Control/status and track bus between the BIST and its environment.
// The BIST side uses the master modport; the channel/controller side uses slave.
interface chany_track_bist_if
  import chany_bist_pkg::*;
#(
  parameter int CHAN_WIDTH = 30
) ();

  localparam int ERR_W = err_w(CHAN_WIDTH);

  logic                  start;
  logic                  busy;
  logic                  done;
  logic                  pass;
  logic [ERR_W-1:0]      err_cnt;
  logic [7:0]            first_fail_idx;
  logic [CHAN_WIDTH-1:0] first_fail_mask;
  logic [CHAN_WIDTH-1:0] tx_track;
  logic [CHAN_WIDTH-1:0] rx_track;
  logic [CHAN_WIDTH-1:0] rx_mid;

  modport master (
    input  start, rx_track, rx_mid,
    output busy, done, pass, err_cnt, first_fail_idx, first_fail_mask, tx_track
  );

  modport slave (
    output start, rx_track, rx_mid,
    input  busy, done, pass, err_cnt, first_fail_idx, first_fail_mask, tx_track
  );

endinterface

// File: rtl/chany_bist_patgen.sv
// Combinational test-pattern generator: zeros, ones, two checkerboards,
// then walking-one and walking-zero across every track.
module chany_bist_patgen
  import chany_bist_pkg::*;
#(
  parameter int CHAN_WIDTH = 30,
  parameter int PI_W       = 6
) (
  input  logic [PI_W-1:0]       pat_idx,
  output logic [CHAN_WIDTH-1:0] pattern
);

  localparam int NUM_PAT = num_pat(CHAN_WIDTH);

  int idx;

  // NOTE: every output of a combinational block gets a default before any
  // branch, so no path can leave it unassigned and infer a latch.
  always_comb begin
    idx     = int'(pat_idx);
    pattern = '0;
    if (idx == PAT_ZERO) begin
      pattern = '0;
    end else if (idx == PAT_ONE) begin
      pattern = '1;
    end else if (idx == PAT_CBA || idx == PAT_CBB) begin
      // Checkerboard A has even tracks high; B is its complement.
      for (int i = 0; i < CHAN_WIDTH; i++)
        pattern[i] = ((i % 2) == 0) ^ (idx == PAT_CBB);
    end else if (idx < PAT_WALK1 + CHAN_WIDTH) begin
      for (int i = 0; i < CHAN_WIDTH; i++)
        pattern[i] = (idx == PAT_WALK1 + i);
    end else if (idx < NUM_PAT) begin
      for (int i = 0; i < CHAN_WIDTH; i++)
        pattern[i] = (idx != PAT_WALK1 + CHAN_WIDTH + i);
    end
  end

endmodule

// File: rtl/chany_track_bist.sv
// Y-channel track BIST: drives each pattern for SETTLE_CYC+1 cycles, compares
// the returned tracks, and records error count and first failure.
// Define CHANY_BIST_MID_CHECK_EN to also check rx_mid against the pattern.
module chany_track_bist
  import chany_bist_pkg::*;
#(
  parameter int CHAN_WIDTH = 30,
  parameter int SETTLE_CYC = 2
) (
  input logic                 clk,
  input logic                 Reset,
  chany_track_bist_if.master  bus
);

  localparam int NUM_PAT = num_pat(CHAN_WIDTH);
  localparam int ERR_W   = err_w(CHAN_WIDTH);
  localparam int PI_W    = $clog2(NUM_PAT);
  localparam int SC_W    = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  state_t                state, state_n;
  logic [PI_W-1:0]       pat_idx, pat_idx_n;
  logic [SC_W-1:0]       settle, settle_n;
  logic [ERR_W-1:0]      err, err_n;
  logic [7:0]            ff_idx, ff_idx_n;
  logic [CHAN_WIDTH-1:0] ff_mask, ff_mask_n;
  logic                  ff_seen, ff_seen_n;
  logic [CHAN_WIDTH-1:0] pattern, mism;
  logic                  active;

  chany_bist_patgen #(.CHAN_WIDTH(CHAN_WIDTH), .PI_W(PI_W)) u_patgen (
    .pat_idx (pat_idx),
    .pattern (pattern)
  );

`ifdef CHANY_BIST_MID_CHECK_EN
  assign mism = (bus.rx_track ^ pattern) | (bus.rx_mid ^ pattern);
`else
  assign mism = bus.rx_track ^ pattern;
`endif

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state   <= IDLE;
      pat_idx <= '0;
      settle  <= '0;
      err     <= '0;
      ff_idx  <= '0;
      ff_mask <= '0;
      ff_seen <= 1'b0;
    end else begin
      state   <= state_n;
      pat_idx <= pat_idx_n;
      settle  <= settle_n;
      err     <= err_n;
      ff_idx  <= ff_idx_n;
      ff_mask <= ff_mask_n;
      ff_seen <= ff_seen_n;
    end
  end

  always_comb begin
    state_n   = state;
    pat_idx_n = pat_idx;
    settle_n  = settle;
    err_n     = err;
    ff_idx_n  = ff_idx;
    ff_mask_n = ff_mask;
    ff_seen_n = ff_seen;
    case (state)
      IDLE, DONE: begin
        if (bus.start) begin
          state_n   = DRIVE;
          pat_idx_n = '0;
          settle_n  = SC_W'(SETTLE_CYC - 1);
          err_n     = '0;
          ff_idx_n  = '0;
          ff_mask_n = '0;
          ff_seen_n = 1'b0;
        end
      end
      DRIVE: begin
        if (settle == '0) state_n  = CHECK;
        else              settle_n = settle - SC_W'(1);
      end
      CHECK: begin
        if (mism != '0) begin
          if (err != '1) err_n = err + ERR_W'(1);
          if (!ff_seen) begin
            ff_seen_n = 1'b1;
            ff_idx_n  = 8'(pat_idx);
            ff_mask_n = mism;
          end
        end
        if (pat_idx == PI_W'(NUM_PAT - 1)) begin
          state_n = DONE;
        end else begin
          pat_idx_n = pat_idx + PI_W'(1);
          settle_n  = SC_W'(SETTLE_CYC - 1);
          state_n   = DRIVE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign active              = (state == DRIVE) || (state == CHECK);
  assign bus.busy            = active;
  assign bus.done            = (state == DONE);
  assign bus.pass            = (state == DONE) && (err == '0);
  assign bus.err_cnt         = err;
  assign bus.first_fail_idx  = ff_idx;
  assign bus.first_fail_mask = ff_mask;
  assign bus.tx_track        = active ? pattern : '0;

endmodule

// File: tb/tb_chany_track_bist.sv
// Directed bench for chany_track_bist: fault-injecting loopback, expected
// results queued at each start and compared when done rises.
module tb_chany_track_bist;

  localparam int W       = 30;
  localparam int SETTLE  = 2;
  localparam int NUM_PAT = 2 * W + 4;
  localparam int RUN_CYC = NUM_PAT * (SETTLE + 1);

  typedef struct {
    int           lat;
    int           err;
    int           idx;
    logic [W-1:0] mask;
    logic         pass;
  } exp_t;

  logic clk = 1'b0;
  logic Reset;
  int   fault = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sb[$];

  chany_track_bist_if #(.CHAN_WIDTH(W)) bus ();

  chany_track_bist #(.CHAN_WIDTH(W), .SETTLE_CYC(SETTLE)) dut (
    .clk   (clk),
    .Reset (Reset),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  // Channel model: ideal loopback with a selectable planted fault.
  always_comb begin
    bus.rx_track = bus.tx_track;
    bus.rx_mid   = bus.tx_track;
    case (fault)
      1: bus.rx_track[5] = 1'b0;
      2: bus.rx_mid[0]   = 1'b1;
      3: begin
        bus.rx_track[3] = bus.tx_track[4];
        bus.rx_track[4] = bus.tx_track[3];
      end
      default: ;
    endcase
  end

  function automatic logic [W-1:0] pat_model(input int k);
    logic [W-1:0] one;
    one = {{(W-1){1'b0}}, 1'b1};
    if (k == 0)          return '0;
    else if (k == 1)     return '1;
    else if (k == 2)     return {(W/2){2'b01}};
    else if (k == 3)     return {(W/2){2'b10}};
    else if (k < 4 + W)  return one << (k - 4);
    else                 return ~(one << (k - 4 - W));
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk) bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  // One full run: queue expectation, track tx patterns, wait (bounded) for done.
  task automatic run(input string name, input int f, input int repulse,
                     input exp_t e, input bit chk_tx);
    int   lat;
    exp_t got;
    fault = f;
    pulse_start();
    sb.push_back(e);
    lat = 0;
    for (int n = 1; n <= RUN_CYC + 20; n++) begin
      @(posedge clk);
      #1;
      bus.start = (n == repulse);
      if (chk_tx && n < RUN_CYC && (n % (SETTLE + 1)) == 1)
        check($sformatf("%s_tx_pat%0d", name, n / (SETTLE + 1)),
              bus.tx_track, pat_model(n / (SETTLE + 1)));
      if (chk_tx && n == 1) check({name, "_busy"}, bus.busy, 1);
      if (bus.done) begin
        lat = n;
        break;
      end
    end
    bus.start = 1'b0;
    got = sb.pop_front();
    check({name, "_latency"}, lat, got.lat);
    check({name, "_err_cnt"}, bus.err_cnt, got.err);
    check({name, "_ff_idx"},  bus.first_fail_idx, got.idx);
    check({name, "_ff_mask"}, bus.first_fail_mask, got.mask);
    check({name, "_pass"},    bus.pass, got.pass);
    check({name, "_busy_end"}, bus.busy, 0);
  endtask

  initial begin
    exp_t ideal, e;
    ideal = '{RUN_CYC, 0, 0, '0, 1'b1};
    bus.start = 1'b0;
    Reset = 1'b0;
    #1 Reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy",    bus.busy, 0);
    check("rst_done",    bus.done, 0);
    check("rst_pass",    bus.pass, 0);
    check("rst_err_cnt", bus.err_cnt, 0);
    check("rst_ff_idx",  bus.first_fail_idx, 0);
    check("rst_ff_mask", bus.first_fail_mask, 0);
    check("rst_tx",      bus.tx_track, 0);
    @(negedge clk) Reset = 1'b0;

    run("ideal", 0, 0, ideal, 1'b1);

    e = '{RUN_CYC, 32, 1, 30'h20, 1'b0};
    run("stuck0_t5", 1, 0, e, 1'b0);

    e = '{RUN_CYC, 6, 2, 30'h18, 1'b0};
    run("swap_t3_t4", 3, 0, e, 1'b0);

    // Restart from DONE must clear the previous failing results.
    run("restart_ideal", 0, 0, ideal, 1'b0);

`ifdef CHANY_BIST_MID_CHECK_EN
    e = '{RUN_CYC, 32, 0, 30'h1, 1'b0};
`else
    e = ideal;
`endif
    run("mid_stuck1_m0", 2, 0, e, 1'b0);

    run("repulse40", 0, 40, ideal, 1'b0);

    // Reset mid-run: results so far are discarded.
    fault = 1;
    pulse_start();
    repeat (49) @(posedge clk);
    #1;
    check("pre_reset_err_cnt", bus.err_cnt, 3);
    #1 Reset = 1'b1;
    #1;
    check("mid_reset_busy",    bus.busy, 0);
    check("mid_reset_tx",      bus.tx_track, 0);
    check("mid_reset_err_cnt", bus.err_cnt, 0);
    check("mid_reset_done",    bus.done, 0);
    check("mid_reset_ff_mask", bus.first_fail_mask, 0);
    @(negedge clk) Reset = 1'b0;

    run("post_reset_ideal", 0, 0, ideal, 1'b0);

    check("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
